// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 requester.
// FSM state encoding and APB4 PPROT bit positions.
package apb4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } apb4_state_e;

   localparam logic [2:0] PROT_PRIV   = 3'b001;
   localparam logic [2:0] PROT_NONSEC = 3'b010;
   localparam logic [2:0] PROT_INSTR  = 3'b100;

endpackage

// File: rtl/apb4_timeout_cnt.sv
// ACCESS-phase wait counter with clear/enable.
// expired_o flags the count sitting on the threshold.
module apb4_timeout_cnt #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] thresh_i,
   output logic         expired_o
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_cnt <= '0;
      end else if (en_i) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign expired_o = (r_cnt == thresh_i);

endmodule

// File: rtl/apb4_req_master.sv
// APB4 requester: one request/response transfer at a time.
// IDLE -> SETUP -> ACCESS (wait/timeout) -> RESP -> IDLE.
module apb4_req_master
   import apb4_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_write_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
   input  logic [2:0]              req_prot_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    rsp_timeout_o,
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic [2:0]              pprot_o,
   output logic                    psel_o,
   output logic                    penable_o,
   output logic                    pwrite_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   input  logic                    pready_i,
   input  logic [DATA_WIDTH-1:0]   prdata_i,
   input  logic                    pslverr_i
);

   localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int THR_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] THR = THR_I[CW-1:0];

   apb4_state_e             r_state;
   logic                    r_req_ready;
   logic                    r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic                    r_rsp_err;
   logic                    r_rsp_to;
   logic [ADDR_WIDTH-1:0]   r_paddr;
   logic [2:0]              r_pprot;
   logic                    r_psel;
   logic                    r_penable;
   logic                    r_pwrite;
   logic [DATA_WIDTH-1:0]   r_pwdata;
   logic [DATA_WIDTH/8-1:0] r_pstrb;

   logic w_tmo_clr;
   logic w_tmo_en;
   logic w_expired;
   logic w_timeout;

   // Clearing during SETUP makes the first ACCESS cycle see a count of 0.
   assign w_tmo_clr = (r_state == ST_SETUP);
   assign w_tmo_en  = (r_state == ST_ACCESS) && !pready_i;
   assign w_timeout = (TIMEOUT_CYCLES != 0) && w_expired;

   apb4_timeout_cnt #(
      .W (CW)
   ) u_tmo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (w_tmo_clr),
      .en_i      (w_tmo_en),
      .thresh_i  (THR),
      .expired_o (w_expired)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_to    <= 1'b0;
         r_paddr     <= '0;
         r_pprot     <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_pstrb     <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (req_valid_i && r_req_ready) begin
                  r_paddr     <= req_addr_i;
                  r_pprot     <= req_prot_i;
                  r_pwrite    <= req_write_i;
                  r_pwdata    <= req_wdata_i;
                  r_pstrb     <= req_write_i ? req_wstrb_i : '0;
                  r_psel      <= 1'b1;
                  r_req_ready <= 1'b0;
                  r_state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // A completer answer on the threshold cycle beats the timeout.
               if (pready_i) begin
                  r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
                  r_rsp_err   <= pslverr_i;
                  r_rsp_to    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_state     <= ST_RESP;
               end else if (w_timeout) begin
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_to    <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign req_ready_o   = r_req_ready;
   assign rsp_valid_o   = r_rsp_valid;
   assign rsp_rdata_o   = r_rsp_rdata;
   assign rsp_err_o     = r_rsp_err;
   assign rsp_timeout_o = r_rsp_to;
   assign paddr_o       = r_paddr;
   assign pprot_o       = r_pprot;
   assign psel_o        = r_psel;
   assign penable_o     = r_penable;
   assign pwrite_o      = r_pwrite;
   assign pwdata_o      = r_pwdata;
   assign pstrb_o       = r_pstrb;

endmodule

// File: tb/tb_apb4_req_master.sv
// Directed bench for apb4_req_master (TIMEOUT_CYCLES=8).
module tb_apb4_req_master;
   import apb4_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic [2:0]  req_prot = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_to;
   logic [31:0] paddr;
   logic [2:0]  pprot;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready = 1'b0;
   logic [31:0] prdata = '0;
   logic        pslverr = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   apb4_req_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_write_i   (req_write),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .req_wstrb_i   (req_wstrb),
      .req_prot_i    (req_prot),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_err_o     (rsp_err),
      .rsp_timeout_o (rsp_to),
      .paddr_o       (paddr),
      .pprot_o       (pprot),
      .psel_o        (psel),
      .penable_o     (penable),
      .pwrite_o      (pwrite),
      .pwdata_o      (pwdata),
      .pstrb_o       (pstrb),
      .pready_i      (pready),
      .prdata_i      (prdata),
      .pslverr_i     (pslverr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one transfer from IDLE and records what the APB side showed.
   // wait_n < 0 never raises pready; otherwise pready after wait_n waits.
   task automatic do_xfer(
      input  logic        w,
      input  logic [31:0] a,
      input  logic [31:0] d,
      input  logic [3:0]  s,
      input  logic [2:0]  p,
      input  int          wait_n,
      input  logic [31:0] prd,
      input  logic        slv,
      output int          ps,
      output int          pe,
      output int          bad,
      output logic        seen,
      output logic [31:0] rd,
      output logic        er,
      output logic        to
   );
      ps = 0; pe = 0; bad = 0; seen = 1'b0;
      rd = '0; er = 1'b0; to = 1'b0;
      req_write = w; req_addr = a; req_wdata = d;
      req_wstrb = s; req_prot = p; req_valid = 1'b1;
      prdata = prd; pslverr = slv; pready = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         req_valid = 1'b0;
         if (psel) begin
            ps++;
            if (paddr !== a || pwrite !== w || pwdata !== d ||
                pstrb !== (w ? s : 4'h0) || pprot !== p)
               bad++;
         end
         if (psel && penable) begin
            pe++;
            pready = (wait_n >= 0 && pe > wait_n) ? 1'b1 : 1'b0;
         end else begin
            pready = 1'b0;
         end
         if (rsp_valid) begin
            seen = 1'b1;
            rd = rsp_rdata; er = rsp_err; to = rsp_to;
         end
      end
      pready = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready);
      end
      n_cmp++;
      if ({psel, penable, rsp_valid} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_ctl got %b want 000", {psel, penable, rsp_valid});
      end
      n_cmp++;
      if ({paddr, pwdata, rsp_rdata, pstrb, pprot, pwrite, rsp_err, rsp_to} !== '0) begin
         n_bad++; $display("FAIL reset_data got %h/%h/%h want 0", paddr, pwdata, rsp_rdata);
      end
   endtask

   task automatic test_zero_wait_read();
      int ps, pe, bad; logic seen, er, to; logic [31:0] rd;
      do_xfer(1'b0, 32'hFFFF_0000, 32'h0, 4'hF, PROT_PRIV, 0,
              32'h101F_1010, 1'b0, ps, pe, bad, seen, rd, er, to);
      n_cmp++;
      if (ps !== 2 || pe !== 1) begin
         n_bad++; $display("FAIL zw_read_phases got psel=%0d pen=%0d want 2/1", ps, pe);
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++; $display("FAIL zw_read_payload got %0d bad want 0 (pstrb must be 0)", bad);
      end
      n_cmp++;
      if (!seen || rd !== 32'h101F_1010 || er !== 1'b0 || to !== 1'b0) begin
         n_bad++; $display("FAIL zw_read_rsp got seen=%b rd=%h er=%b to=%b want 1/101f1010/0/0",
                           seen, rd, er, to);
      end
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL zw_read_idle got rdy=%b vld=%b want 1/0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_wait_write();
      int ps, pe, bad; logic seen, er, to; logic [31:0] rd;
      do_xfer(1'b1, 32'hFFFF_0008, 32'hDEAD_BEEF, 4'hF, PROT_NONSEC, 3,
              32'h1234_5678, 1'b0, ps, pe, bad, seen, rd, er, to);
      n_cmp++;
      if (ps !== 5 || pe !== 4) begin
         n_bad++; $display("FAIL wr_wait_phases got psel=%0d pen=%0d want 5/4", ps, pe);
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++; $display("FAIL wr_wait_stable got %0d unstable cycles want 0", bad);
      end
      n_cmp++;
      if (!seen || rd !== 32'h0 || er !== 1'b0 || to !== 1'b0) begin
         n_bad++; $display("FAIL wr_wait_rsp got seen=%b rd=%h er=%b to=%b want 1/0/0/0",
                           seen, rd, er, to);
      end
      n_cmp++;
      if (paddr !== 32'hFFFF_0008 || pwdata !== 32'hDEAD_BEEF || pstrb !== 4'hF) begin
         n_bad++; $display("FAIL wr_hold_after got %h/%h/%h want ffff0008/deadbeef/f",
                           paddr, pwdata, pstrb);
      end
   endtask

   task automatic test_slverr_read();
      int ps, pe, bad; logic seen, er, to; logic [31:0] rd;
      do_xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, PROT_INSTR, 1,
              32'hCAFE_0001, 1'b1, ps, pe, bad, seen, rd, er, to);
      pslverr = 1'b0;
      n_cmp++;
      if (bad !== 0 || ps !== 3) begin
         n_bad++; $display("FAIL err_read_payload got bad=%0d psel=%0d want 0/3", bad, ps);
      end
      n_cmp++;
      if (!seen || er !== 1'b1 || to !== 1'b0 || rd !== 32'hCAFE_0001) begin
         n_bad++; $display("FAIL err_read_rsp got seen=%b er=%b to=%b rd=%h want 1/1/0/cafe0001",
                           seen, er, to, rd);
      end
   endtask

   task automatic test_timeout();
      int ps, pe, bad; logic seen, er, to; logic [31:0] rd;
      do_xfer(1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'b000, -1,
              32'h5555_AAAA, 1'b0, ps, pe, bad, seen, rd, er, to);
      n_cmp++;
      if (pe !== 8) begin
         n_bad++; $display("FAIL tmo_access_cycles got %0d want 8", pe);
      end
      n_cmp++;
      if (!seen || er !== 1'b1 || to !== 1'b1 || rd !== 32'h0) begin
         n_bad++; $display("FAIL tmo_rsp got seen=%b er=%b to=%b rd=%h want 1/1/1/0",
                           seen, er, to, rd);
      end
      do_xfer(1'b0, 32'h0000_0204, 32'h0, 4'h0, 3'b000, 7,
              32'h5555_AAAA, 1'b0, ps, pe, bad, seen, rd, er, to);
      n_cmp++;
      if (pe !== 8 || !seen || er !== 1'b0 || to !== 1'b0 || rd !== 32'h5555_AAAA) begin
         n_bad++; $display("FAIL tmo_edge_win got pe=%0d er=%b to=%b rd=%h want 8/0/0/5555aaaa",
                           pe, er, to, rd);
      end
   endtask

   task automatic test_backpressure();
      logic seen;
      int bad;
      rsp_ready = 1'b0;
      req_write = 1'b0; req_addr = 32'h40; req_wdata = '0;
      req_wstrb = '0; req_prot = '0; req_valid = 1'b1;
      prdata = 32'hA5A5_5A5A; pready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         req_valid = 1'b0;
         if (rsp_valid) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_bad++; $display("FAIL bp_rsp_seen got 0 want 1");
      end
      req_write = 1'b1; req_addr = 32'h44; req_wdata = 32'h11;
      req_wstrb = 4'h1; req_valid = 1'b1; prdata = '0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_5A5A ||
             req_ready !== 1'b0 || psel !== 1'b0)
            bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++; $display("FAIL bp_hold got %0d bad cycles want 0", bad);
      end
      rsp_ready = 1'b1;
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || psel !== 1'b0) begin
         n_bad++; $display("FAIL bp_release got vld=%b rdy=%b psel=%b want 0/1/0",
                           rsp_valid, req_ready, psel);
      end
      tick();
      req_valid = 1'b0;
      n_cmp++;
      if (psel !== 1'b1 || paddr !== 32'h44 || pwrite !== 1'b1 || pstrb !== 4'h1) begin
         n_bad++; $display("FAIL bp_pending_accept got psel=%b addr=%h want 1/44", psel, paddr);
      end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      pready = 1'b0;
      n_cmp++;
      if (!seen || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         n_bad++; $display("FAIL bp_second_rsp got seen=%b rd=%h want 1/0", seen, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int ps, pe, bad, vld; logic seen, er, to; logic [31:0] rd;
      req_write = 1'b0; req_addr = 32'h80; req_wdata = '0;
      req_wstrb = '0; req_prot = '0; req_valid = 1'b1; pready = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      n_cmp++;
      if (psel !== 1'b1 || penable !== 1'b1) begin
         n_bad++; $display("FAIL rst_mid_access got psel=%b pen=%b want 1/1", psel, penable);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (psel !== 1'b0 || penable !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++; $display("FAIL rst_mid_abort got psel=%b pen=%b rdy=%b want 0/0/1",
                           psel, penable, req_ready);
      end
      vld = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rsp_valid) vld++;
      end
      n_cmp++;
      if (vld !== 0) begin
         n_bad++; $display("FAIL rst_mid_no_rsp got %0d rsp cycles want 0", vld);
      end
      do_xfer(1'b0, 32'h0000_0084, 32'h0, 4'h0, 3'b000, 0,
              32'h0BAD_F00D, 1'b0, ps, pe, bad, seen, rd, er, to);
      n_cmp++;
      if (!seen || rd !== 32'h0BAD_F00D || er !== 1'b0 || ps !== 2 || bad !== 0) begin
         n_bad++; $display("FAIL rst_mid_next got seen=%b rd=%h ps=%0d want 1/0badf00d/2",
                           seen, rd, ps);
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait_read();
      test_wait_write();
      test_slverr_read();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
